// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the MIPS datapath and the HI/LO multiply/divide unit.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO access.
// Signed operations run on magnitudes; the sign is restored in the FIXUP cycle.
module mul_div_unit #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input logic           clk,
    input logic           rst,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    // r_acc: product upper half / partial remainder; r_shf: multiplier+product lower half / dividend+quotient
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_shf;
    logic [WIDTH-1:0] r_opd;
    logic [WIDTH-1:0] r_rs;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic             r_div0;

    logic             w_signed;
    logic             w_is_div;
    logic             w_accept;
    logic             w_fast;
    logic [WIDTH-1:0] w_rs_mag;
    logic [WIDTH-1:0] w_rt_mag;
    logic [2*WIDTH-1:0] w_fast_prod;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH+1:0] w_div_trial;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // Operand magnitudes, one iteration of shift-add / restoring divide, and sign fixup values
    always_comb begin
        w_signed    = ~bus.op[0];
        w_is_div    = bus.op[1];
        w_accept    = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
        w_fast      = FAST_MUL && !w_is_div;
        w_rs_mag    = (w_signed && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
        w_rt_mag    = (w_signed && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
        w_fast_prod = (2*WIDTH)'(w_rs_mag) * (2*WIDTH)'(w_rt_mag);
        w_mul_sum   = {1'b0, r_acc} + (r_shf[0] ? {1'b0, r_opd} : '0);
        w_div_shift = {r_acc, r_shf[WIDTH-1]};
        w_div_trial = {1'b0, w_div_shift} - {2'b00, r_opd};
        w_prod_fix  = r_neg_res ? -{r_acc, r_shf} : {r_acc, r_shf};
        w_quo_fix   = r_neg_res ? -r_shf : r_shf;
        w_rem_fix   = r_neg_rem ? -r_acc : r_acc;
    end

    // Control FSM, iteration datapath and HI/LO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_acc     <= '0;
            r_shf     <= '0;
            r_opd     <= '0;
            r_rs      <= '0;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_is_div  <= w_is_div;
                        r_rs      <= bus.rs_data;
                        r_div0    <= (bus.rt_data == '0);
                        r_neg_res <= w_signed && (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
                        r_neg_rem <= w_signed && w_is_div && bus.rs_data[WIDTH-1];
                        r_opd     <= w_rt_mag;
                        if (w_fast) begin
                            r_acc   <= w_fast_prod[2*WIDTH-1:WIDTH];
                            r_shf   <= w_fast_prod[WIDTH-1:0];
                            r_state <= S_FIXUP;
                        end else begin
                            r_acc   <= '0;
                            r_shf   <= w_rs_mag;
                            r_state <= S_CALC;
                        end
                    end else begin
                        if (bus.hi_we) r_hi <= bus.rs_data;
                        if (bus.lo_we) r_lo <= bus.rs_data;
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (r_is_div) begin
                        if (!w_div_trial[WIDTH+1]) begin
                            r_acc <= w_div_trial[WIDTH-1:0];
                            r_shf <= {r_shf[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc <= w_div_shift[WIDTH-1:0];
                            r_shf <= {r_shf[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_acc <= w_mul_sum[WIDTH:1];
                        r_shf <= {w_mul_sum[0], r_shf[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH-1)) r_state <= S_FIXUP;
                end
                S_FIXUP: begin
                    if (!r_is_div) begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else if (r_div0) begin
                        r_hi <= r_rs;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: iterative instance plus a FAST_MUL instance.
module tb_mul_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(W)) bus ();
    mul_div_unit_if #(.WIDTH(W)) bus_f ();

    mul_div_unit #(.WIDTH(W), .FAST_MUL(1'b0)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    mul_div_unit #(.WIDTH(W), .FAST_MUL(1'b1)) u_fast (.clk(clk), .rst(rst), .bus(bus_f));

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned due;
    } exp_t;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    exp_t        q[$];
    exp_t        qf[$];
    vec_t        vecs[$];
    int unsigned cyc     = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor for the iterative instance
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus.done === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_done", {31'b0, bus.done}, 32'h0);
            end else begin
                e = q.pop_front();
                check({e.name, "_hi"}, bus.hi, e.hi);
                check({e.name, "_lo"}, bus.lo, e.lo);
                check({e.name, "_cycle"}, cyc, e.due);
            end
        end
    end

    // Monitor for the FAST_MUL instance
    always @(negedge clk) begin : mon_f
        exp_t e;
        if (!rst && bus_f.done === 1'b1) begin
            if (qf.size() == 0) begin
                check("fast_unexpected_done", {31'b0, bus_f.done}, 32'h0);
            end else begin
                e = qf.pop_front();
                check({e.name, "_hi"}, bus_f.hi, e.hi);
                check({e.name, "_lo"}, bus_f.lo, e.lo);
                check({e.name, "_cycle"}, cyc, e.due);
            end
        end
    end

    // Called at a falling edge (cycle 0); returns at the falling edge of cycle 1
    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input bit push);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        if (push) q.push_back('{name: name, hi: ehi, lo: elo, due: cyc + 34});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check({name, "_done_seen"}, {31'b0, seen}, 32'h1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int unsigned bad_busy;
        int unsigned bad_hold;
        bit          seen_f;

        bus.start = 1'b0; bus.op = 2'b00; bus.rs_data = '0; bus.rt_data = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        bus_f.start = 1'b0; bus_f.op = 2'b00; bus_f.rs_data = '0; bus_f.rt_data = '0;
        bus_f.hi_we = 1'b0; bus_f.lo_we = 1'b0;

        vecs.push_back('{"mult_m3x5",   2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1});
        vecs.push_back('{"div_m7d2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
        vecs.push_back('{"divu_100d7",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14});
        vecs.push_back('{"divu_7d0",    2'b11, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF});
        vecs.push_back('{"div_minneg",  2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
        vecs.push_back('{"div_m8d0",    2'b10, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF});
        vecs.push_back('{"mult_minsq",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
        vecs.push_back('{"multu_x16",   2'b01, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780});
        vecs.push_back('{"div_7dm2",    2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_done", {31'b0, bus.done}, 32'h0);
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);

        // MTLO while idle
        @(negedge clk);
        bus.lo_we   = 1'b1;
        bus.rs_data = 32'h1234;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mtlo_lo", bus.lo, 32'h1234);
        check("mtlo_hi", bus.hi, 32'h0);

        // MULTU max with an ignored start + MTHI in cycle 5
        issue("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
        bad_busy = 0;
        bad_hold = 0;
        for (int k = 1; k <= 33; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.busy !== 1'b1) bad_busy++;
            if (bus.hi !== 32'h0 || bus.lo !== 32'h1234) bad_hold++;
            if (k == 5) begin
                bus.start = 1'b1; bus.op = 2'b11; bus.rs_data = 32'hDEAD; bus.rt_data = 32'd1;
                bus.hi_we = 1'b1;
            end
            if (k == 6) begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
            end
        end
        check("busy_cycles_1_33", bad_busy, 32'h0);
        check("hilo_hold_busy", bad_hold, 32'h0);
        @(negedge clk);
        check("busy_low_cycle34", {31'b0, bus.busy}, 32'h0);

        // Back-to-back ops, each started in the DONE cycle of the previous one
        foreach (vecs[i]) begin
            issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b1);
            wait_done(vecs[i].name);
        end

        // Reset in cycle 10 of a DIV aborts it
        @(negedge clk);
        issue("div_abort", 2'b10, 32'd100, 32'd3, 32'h0, 32'h0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'b0, bus.busy}, 32'h0);
        check("abort_done", {31'b0, bus.done}, 32'h0);
        check("abort_hi", bus.hi, 32'h0);
        check("abort_lo", bus.lo, 32'h0);

        // New op accepted after the abort
        @(negedge clk);
        issue("divu_after_rst", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
        wait_done("divu_after_rst");

        // FAST_MUL instance: MULT -3*5 finishes in cycle 2
        @(negedge clk);
        bus_f.start   = 1'b1;
        bus_f.op      = 2'b00;
        bus_f.rs_data = 32'hFFFFFFFD;
        bus_f.rt_data = 32'd5;
        qf.push_back('{name: "fast_mult_m3x5", hi: 32'hFFFFFFFF, lo: 32'hFFFFFFF1, due: cyc + 2});
        @(negedge clk);
        bus_f.start = 1'b0;
        seen_f = 1'b0;
        for (int i = 0; i < 10 && !seen_f; i++) begin
            @(negedge clk);
            if (bus_f.done === 1'b1) seen_f = 1'b1;
        end
        check("fast_done_seen", {31'b0, seen_f}, 32'h1);

        repeat (3) @(negedge clk);
        check("pending_results", q.size(), 32'h0);
        check("pending_fast_results", qf.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
